// File: rtl/oam_dma_if.sv
// Core-side and system-bus-side signals of the sprite DMA engine / bus arbiter.
// The master modport is the DMA engine; slave is the surrounding system (core + memory).
interface oam_dma_if;
  logic [15:0] I_cpu_addr;
  logic [7:0]  I_cpu_wr_data;
  logic        I_cpu_rdwr;
  logic        O_cpu_ready;
  logic [7:0]  O_cpu_rd_data;
  logic [15:0] O_addr;
  logic [7:0]  O_wr_data;
  logic        O_rdwr;
  logic [7:0]  I_rd_data;
  logic        O_busy;

  modport master (
    input  I_cpu_addr, I_cpu_wr_data, I_cpu_rdwr, I_rd_data,
    output O_cpu_ready, O_cpu_rd_data, O_addr, O_wr_data, O_rdwr, O_busy
  );

  modport slave (
    output I_cpu_addr, I_cpu_wr_data, I_cpu_rdwr, I_rd_data,
    input  O_cpu_ready, O_cpu_rd_data, O_addr, O_wr_data, O_rdwr, O_busy
  );
endinterface

// File: rtl/oam_dma.sv
// Sprite DMA engine: snoops core writes to DMA_REG, halts the core and copies one
// 256-byte page to OAM_DATA as get/put cycle pairs; otherwise passes the core through.
module oam_dma #(
  parameter int          CYCLE_TICKS = 12,
  parameter logic [15:0] DMA_REG     = 16'h4014,
  parameter logic [15:0] OAM_DATA    = 16'h2004
) (
  input logic      I_clock,
  input logic      I_reset,
  oam_dma_if.master bus
);

  localparam int TICK_W = (CYCLE_TICKS > 1) ? $clog2(CYCLE_TICKS) : 1;

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] HALT  = 3'd1;
  localparam logic [2:0] ALIGN = 3'd2;
  localparam logic [2:0] READ  = 3'd3;
  localparam logic [2:0] WRITE = 3'd4;

  logic [TICK_W-1:0] tick;
  logic              strobe;
  logic              parity;
  logic [2:0]        state;
  logic              pending;
  logic [7:0]        page;
  logic [7:0]        idx;
  logic [7:0]        latch;
  logic              trigger;

  // Free-running phase counter; never gated by ready so DMA and core phases stay locked.
  always_ff @(posedge I_clock or negedge I_reset) begin
    if (!I_reset) begin
      tick <= '0;
    end else if (tick == TICK_W'(CYCLE_TICKS - 1)) begin
      tick <= '0;
    end else begin
      tick <= tick + 1'b1;
    end
  end

  assign strobe  = (tick == '0);
  assign trigger = bus.O_cpu_ready && (bus.I_cpu_addr == DMA_REG) && !bus.I_cpu_rdwr;

  // NOTE: sequential state uses non-blocking assignments so every register in this
  // block samples the pre-edge values of its neighbours, regardless of statement order.
  always_ff @(posedge I_clock or negedge I_reset) begin
    if (!I_reset) begin
      parity  <= 1'b0;
      state   <= IDLE;
      pending <= 1'b0;
      page    <= '0;
      idx     <= '0;
      latch   <= '0;
    end else if (strobe) begin
      parity <= ~parity;
      if (trigger) begin
        page    <= bus.I_cpu_wr_data;
        pending <= 1'b1;
      end
      case (state)
        // Core writes are never halted; wait for its first read cycle.
        IDLE:    if (pending && bus.I_cpu_rdwr) state <= HALT;
        HALT:    state <= parity ? READ : ALIGN;
        ALIGN:   state <= READ;
        READ: begin
          latch <= bus.I_rd_data;
          state <= WRITE;
        end
        WRITE: begin
          idx <= idx + 8'd1;
          if (idx == 8'hFF) begin
            state   <= IDLE;
            pending <= 1'b0;
          end else begin
            state <= READ;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // The core is halted exactly while the engine owns the bus.
  assign bus.O_cpu_ready   = (state == IDLE);
  assign bus.O_busy        = (state != IDLE);
  assign bus.O_cpu_rd_data = bus.I_rd_data;

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    bus.O_addr    = bus.I_cpu_addr;
    bus.O_wr_data = bus.I_cpu_wr_data;
    bus.O_rdwr    = bus.I_cpu_rdwr;
    case (state)
      HALT, ALIGN: bus.O_rdwr = 1'b1;
      READ: begin
        bus.O_addr = {page, idx};
        bus.O_rdwr = 1'b1;
      end
      WRITE: begin
        bus.O_addr    = OAM_DATA;
        bus.O_wr_data = latch;
        bus.O_rdwr    = 1'b0;
      end
      default: ;
    endcase
  end

endmodule
